dram_bram_responder: RTL and testbench
======================================

Name: dram_bram_responder

Overview:
- Responder (slave) end of the DRAM request interface driven by dma_controller: dram_req_read/dram_req_write, 24-bit dram_addr, 32-bit data.
- Serves each request from an on-chip block RAM after a programmable latency.
- Returns dram_data_valid or dram_write_complete as a one-cycle pulse.
- Used on boards without SDRAM and as a cycle-accurate DRAM stand-in in benches.

Parameters:
- ADDR_WIDTH, 12, log2 of memory depth in 32-bit words; dram_addr[ADDR_WIDTH-1:0] selects the word.
- READ_LATENCY, 4, clock edges from request acceptance to data_valid assertion; legal range 1..15.
- WRITE_LATENCY, 3, clock edges from request acceptance to write_complete assertion; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- dram_req_read  input  1  level read request, held by requester until dram_data_valid.
- dram_req_write  input  1  level write request, held by requester until dram_write_complete.
- dram_addr  input  24  word address; bits above ADDR_WIDTH-1 ignored (aliasing).
- dram_data_in  input  32  write data (requester's dram_data_out).
- dram_data_out  output  32  read data (requester's dram_data_in).
- dram_data_valid  output  1  one-cycle pulse; dram_data_out valid in that cycle.
- dram_write_complete  output  1  one-cycle pulse; write committed.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: dram_data_out=0, dram_data_valid=0, dram_write_complete=0, busy=0, state=IDLE, counter=0.
- RAM contents are not cleared by reset.
- States: IDLE, RD_WAIT, WR_WAIT, HOLDOFF.
- IDLE:
  - Samples the request lines each edge.
  - dram_req_write=1: latch addr and data, load counter with WRITE_LATENCY-1, go to WR_WAIT.
  - Otherwise dram_req_read=1: latch addr, load counter with READ_LATENCY-1, go to RD_WAIT.
  - Both high at once: write wins; the read is not queued and must be re-presented by the requester.
- RD_WAIT:
  - Counter decrements each edge.
  - On the edge where the counter is 0: dram_data_out <= mem[latched addr], dram_data_valid <= 1, go to HOLDOFF.
  - Result: data_valid is high exactly READ_LATENCY edges after the acceptance edge.
- WR_WAIT:
  - Same counting as RD_WAIT.
  - On the edge where the counter is 0: mem[latched addr] <= latched data, dram_write_complete <= 1, go to HOLDOFF.
  - The write is committed to the RAM only on this edge.
- HOLDOFF:
  - Lasts exactly one cycle; request lines are ignored; pulses clear to 0; next state IDLE.
  - The requester must drop its request in the pulse cycle or the following cycle. A request still high in IDLE after that starts a new transaction.
- Input stability: addr and data are sampled only at acceptance. Changes while busy have no effect.
- Request deasserted while busy: the transaction still completes and pulses (no cancel).
- dram_data_out holds its value until the next read completes. Writes never change it.
- Reset mid-operation: the pending write is discarded (RAM unchanged), no pulse is issued, return to IDLE.
- Read-after-write to the same address returns the new data; the write commits before HOLDOFF.
- Address aliasing: addresses wrap modulo 2^ADDR_WIDTH.
- Throughput: one transaction per LATENCY+2 cycles maximum.

Decomposition:
- Add to cpu_constants.vh:
  - DRAM_RSP_IDLE/RD_WAIT/WR_WAIT/HOLDOFF 2-bit state encodings.
  - Default latency constants.
- Sub-module dram_model_ram:
  - Single-port synchronous RAM, 2^ADDR_WIDTH x 32.
  - Ports: clk, we, addr, din, dout.
  - Read data registered, so it infers block RAM.
  - The FSM issues the RAM read one cycle before counter==0 so that dout lands on the valid edge. With READ_LATENCY=1 the read is issued on the acceptance edge using the live address.

Test Plan:
- Reset then idle: rst high 2 cycles, all request lines 0 -> every output 0, busy 0, for 10 cycles.
- Basic write then read:
  - Write addr 0x000010, data 0xDEADBEEF, defaults -> write_complete pulses exactly 3 edges after acceptance, for 1 cycle.
  - Then read 0x000010 -> data_valid pulses 4 edges after acceptance, data_out=0xDEADBEEF.
- DMA-style write held until complete: req_write held until the pulse (responder model of the original bench) -> exactly one pulse; req dropped in the pulse cycle; no second transaction.
- Simultaneous requests: req_read=req_write=1, addr 0x5, data 0x12345678 -> only write_complete pulses; a subsequent read of 0x5 returns 0x12345678.
- Aliasing, ADDR_WIDTH=12: write 0xCAFEF00D to 0x001003, read 0x000003 -> 0xCAFEF00D.
- Reset mid-write: preload mem[7]=0x11111111, write 0x22222222 to 7, assert rst 1 edge after acceptance -> no write_complete, busy 0 next cycle; reading 7 returns 0x11111111.

Source files
------------

// File: rtl/dram_bram_responder_pkg.sv
// Shared types and default constants for the block-RAM backed DRAM responder.
package dram_bram_responder_pkg;

  typedef enum logic [1:0] {
    DRAM_RSP_IDLE    = 2'd0,
    DRAM_RSP_RD_WAIT = 2'd1,
    DRAM_RSP_WR_WAIT = 2'd2,
    DRAM_RSP_HOLDOFF = 2'd3
  } rsp_state_e;

  localparam int DRAM_RSP_ADDR_WIDTH    = 12;
  localparam int DRAM_RSP_READ_LATENCY  = 4;
  localparam int DRAM_RSP_WRITE_LATENCY = 3;
  localparam int DRAM_RSP_DATA_WIDTH    = 32;

endpackage

// File: rtl/dram_bram_responder_ram.sv
// Single-port synchronous RAM with a registered read port so it maps onto block RAM.
module dram_model_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/dram_bram_responder.sv
// DRAM request responder: serves read/write requests from block RAM after a fixed,
// programmable number of clock edges and answers with one-cycle completion pulses.
module dram_bram_responder
  import dram_bram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = DRAM_RSP_ADDR_WIDTH,
  parameter int READ_LATENCY  = DRAM_RSP_READ_LATENCY,
  parameter int WRITE_LATENCY = DRAM_RSP_WRITE_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dram_req_read,
  input  logic        dram_req_write,
  input  logic [23:0] dram_addr,
  input  logic [31:0] dram_data_in,
  output logic [31:0] dram_data_out,
  output logic        dram_data_valid,
  output logic        dram_write_complete,
  output logic        busy,
  output rsp_state_e  fsm_state
);

  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

  rsp_state_e            state;
  rsp_state_e            state_next;
  logic [3:0]            count;
  logic                  count_zero;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_dout;
  logic                  ram_we;
  logic                  unused_addr;

  // Upper address bits alias onto the same words.
  assign unused_addr = ^dram_addr;
  assign count_zero  = (count == 4'd0);
  assign fsm_state   = state;

  // State register plus the datapath registers it controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= DRAM_RSP_IDLE;
      count               <= 4'd0;
      dram_data_out       <= 32'd0;
      dram_data_valid     <= 1'b0;
      dram_write_complete <= 1'b0;
    end else begin
      state               <= state_next;
      dram_data_valid     <= 1'b0;
      dram_write_complete <= 1'b0;
      case (state)
        DRAM_RSP_IDLE: begin
          if (dram_req_write) begin
            addr_q <= dram_addr[ADDR_WIDTH-1:0];
            data_q <= dram_data_in;
            count  <= WR_LOAD;
          end else if (dram_req_read) begin
            addr_q <= dram_addr[ADDR_WIDTH-1:0];
            count  <= RD_LOAD;
          end
        end
        DRAM_RSP_RD_WAIT: begin
          if (count_zero) begin
            dram_data_out   <= ram_dout;
            dram_data_valid <= 1'b1;
          end else begin
            count <= count - 4'd1;
          end
        end
        DRAM_RSP_WR_WAIT: begin
          if (count_zero) dram_write_complete <= 1'b1;
          else            count <= count - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DRAM_RSP_IDLE: begin
        if (dram_req_write)     state_next = DRAM_RSP_WR_WAIT;
        else if (dram_req_read) state_next = DRAM_RSP_RD_WAIT;
      end
      DRAM_RSP_RD_WAIT: if (count_zero) state_next = DRAM_RSP_HOLDOFF;
      DRAM_RSP_WR_WAIT: if (count_zero) state_next = DRAM_RSP_HOLDOFF;
      DRAM_RSP_HOLDOFF: state_next = DRAM_RSP_IDLE;
      default:          state_next = DRAM_RSP_IDLE;
    endcase
  end

  // The RAM reads every edge; in IDLE it follows the live address so a one-edge
  // read latency still has its word ready on the valid edge.
  always_comb begin
    busy     = (state != DRAM_RSP_IDLE);
    ram_we   = (state == DRAM_RSP_WR_WAIT) && count_zero && !rst;
    ram_addr = (state == DRAM_RSP_IDLE) ? dram_addr[ADDR_WIDTH-1:0] : addr_q;
  end

  dram_model_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (data_q),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_dram_bram_responder.sv
// Bench for dram_bram_responder: transaction-level model with per-cycle compare
// plus directed transactions with hand-computed latencies and data.
module tb_dram_bram_responder;
  import dram_bram_responder_pkg::*;

  localparam int RL = 4;
  localparam int WL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dram_req_read = 1'b0;
  logic        dram_req_write = 1'b0;
  logic [23:0] dram_addr = 24'd0;
  logic [31:0] dram_data_in = 32'd0;
  logic [31:0] dram_data_out;
  logic        dram_data_valid;
  logic        dram_write_complete;
  logic        busy;
  rsp_state_e  fsm_state;

  int total = 0;
  int bad = 0;

  dram_bram_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .dram_req_read       (dram_req_read),
    .dram_req_write      (dram_req_write),
    .dram_addr           (dram_addr),
    .dram_data_in        (dram_data_in),
    .dram_data_out       (dram_data_out),
    .dram_data_valid     (dram_data_valid),
    .dram_write_complete (dram_write_complete),
    .busy                (busy),
    .fsm_state           (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A request seen on an edge at or after free_edge is accepted; it completes
  // LATENCY edges later, and the responder samples again two edges after that.
  logic [31:0] m_mem [int];
  int          edge_n = 0;
  int          free_edge = 0;
  int          due = -100;
  bit          pend = 0;
  bit          p_wr = 0;
  int          p_a = 0;
  logic [31:0] p_d = 0;
  logic [31:0] m_dout = 0;
  bit          m_known = 1;
  bit          m_valid = 0;
  bit          m_wc = 0;
  bit          m_busy = 0;

  always @(posedge clk) begin
    edge_n++;
    m_valid = 0;
    m_wc = 0;
    if (rst) begin
      pend = 0;
      due = -100;
      free_edge = edge_n + 1;
      m_dout = 0;
      m_known = 1;
      m_busy = 0;
    end else begin
      if (pend && edge_n == due) begin
        pend = 0;
        if (p_wr) begin
          m_mem[p_a] = p_d;
          m_wc = 1;
        end else begin
          m_known = m_mem.exists(p_a);
          if (m_known) m_dout = m_mem[p_a];
          m_valid = 1;
        end
      end else if (!pend && edge_n >= free_edge && (dram_req_write || dram_req_read)) begin
        pend = 1;
        p_wr = dram_req_write;
        p_a = int'(dram_addr[11:0]);
        p_d = dram_data_in;
        due = edge_n + (p_wr ? WL : RL);
        free_edge = due + 2;
      end
      m_busy = pend || (edge_n == due);
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (edge_n > 0) begin
      check("cyc_data_valid", 32'(dram_data_valid), 32'(m_valid));
      check("cyc_write_complete", 32'(dram_write_complete), 32'(m_wc));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      if (m_known) check("cyc_data_out", dram_data_out, m_dout);
    end
  end

  // ---------------- driver ----------------
  // Presents a request at a negedge and waits for its pulse. With hold=1 the
  // request stays up until the pulse cycle (DMA style); otherwise it is dropped
  // after one edge and addr/data are scrambled while the responder is busy.
  task automatic do_txn(input bit wr, input bit rd, input logic [23:0] a, input logic [31:0] d,
                        input bit hold, output int lat, output bit got_valid,
                        output bit got_wc, output logic [31:0] rdata);
    int k;
    bit got;
    @(negedge clk);
    dram_req_write = wr;
    dram_req_read = rd;
    dram_addr = a;
    dram_data_in = d;
    k = 0;
    got = 0;
    got_valid = 0;
    got_wc = 0;
    rdata = 0;
    lat = -1;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (!hold) begin
        dram_req_write = 0;
        dram_req_read = 0;
        dram_addr = 24'($urandom);
        dram_data_in = $urandom;
      end
      if (dram_write_complete || dram_data_valid) begin
        got = 1;
        got_valid = dram_data_valid;
        got_wc = dram_write_complete;
        rdata = dram_data_out;
        lat = k - 1;
      end
    end
    dram_req_write = 0;
    dram_req_read = 0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL txn_timeout: got no pulse expected pulse within 40 cycles (addr %h)", a);
    end
  endtask

  typedef struct { logic [23:0] a; logic [31:0] d; } vec_t;
  vec_t vecs[4];

  initial begin
    int          lat;
    bit          gv;
    bit          gw;
    logic [31:0] rd;

    vecs[0] = '{24'h000abc, 32'h0badf00d};
    vecs[1] = '{24'h000fff, 32'hffffffff};
    vecs[2] = '{24'h000000, 32'h00000001};
    vecs[3] = '{24'hfff123, 32'ha5a55a5a};

    // Reset then idle.
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      check("idle_data_out", dram_data_out, 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_valid", 32'(dram_data_valid), 32'h0);
      check("idle_wc", 32'(dram_write_complete), 32'h0);
    end

    // Basic write (held, DMA style) then idle with no second transaction.
    do_txn(1, 0, 24'h000010, 32'hdeadbeef, 1, lat, gv, gw, rd);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_pulse_kind", 32'({gw, gv}), 32'b10);
    repeat (5) begin
      @(negedge clk);
      check("after_wr_busy", 32'(busy), 32'h0);
      check("after_wr_wc", 32'(dram_write_complete), 32'h0);
    end

    // Read back, held and then dropped early with scrambled inputs.
    do_txn(0, 1, 24'h000010, 32'h0, 1, lat, gv, gw, rd);
    check("rd_latency", 32'(lat), 32'd4);
    check("rd_data", rd, 32'hdeadbeef);
    do_txn(0, 1, 24'h000010, 32'h0, 0, lat, gv, gw, rd);
    check("rd_nohold_latency", 32'(lat), 32'd4);
    check("rd_nohold_data", rd, 32'hdeadbeef);

    // Simultaneous read and write: write wins, read dropped.
    do_txn(1, 1, 24'h000005, 32'h12345678, 1, lat, gv, gw, rd);
    check("both_pulse_kind", 32'({gw, gv}), 32'b10);
    check("both_latency", 32'(lat), 32'd3);
    check("both_data_out_kept", dram_data_out, 32'hdeadbeef);
    repeat (3) begin
      @(negedge clk);
      check("both_no_read", 32'(dram_data_valid), 32'h0);
    end
    do_txn(0, 1, 24'h000005, 32'h0, 1, lat, gv, gw, rd);
    check("both_readback", rd, 32'h12345678);

    // Aliasing above bit 11.
    do_txn(1, 0, 24'h001003, 32'hcafef00d, 1, lat, gv, gw, rd);
    do_txn(0, 1, 24'h000003, 32'h0, 1, lat, gv, gw, rd);
    check("alias_data", rd, 32'hcafef00d);

    // Table of write/read pairs, including the highest word and an aliased one.
    foreach (vecs[i]) begin
      do_txn(1, 0, vecs[i].a, vecs[i].d, (i % 2) == 0, lat, gv, gw, rd);
      check("tbl_wr_latency", 32'(lat), 32'd3);
    end
    foreach (vecs[i]) begin
      do_txn(0, 1, vecs[i].a & 24'h000fff, 32'h0, 1, lat, gv, gw, rd);
      check("tbl_rd_data", rd, vecs[i].d);
    end

    // Reset mid-write: RAM must keep its old word.
    do_txn(1, 0, 24'h000007, 32'h11111111, 1, lat, gv, gw, rd);
    @(negedge clk);
    dram_req_write = 1;
    dram_addr = 24'h000007;
    dram_data_in = 32'h22222222;
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1;
    dram_req_write = 0;
    @(negedge clk);
    rst = 0;
    check("midrst_busy_after", 32'(busy), 32'h0);
    check("midrst_data_out", dram_data_out, 32'h0);
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_wc", 32'(dram_write_complete), 32'h0);
    end
    do_txn(0, 1, 24'h000007, 32'h0, 1, lat, gv, gw, rd);
    check("midrst_readback", rd, 32'h11111111);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
